// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes, D-cache miss service with timeout.
// Controls are combinational from state and inputs (0-cycle); a miss freezes the pipe until the fill completes.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MISS_TIMEOUT = 255,
  parameter int CNTW         = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ifid_rs1,
  input  logic [4:0]      ifid_rs2,
  input  logic            ifid_use1,
  input  logic            ifid_use2,
  input  logic            idex_memread,
  input  logic [4:0]      idex_rd,
  input  logic            branch_taken,
  input  logic            exmem_memread,
  input  logic            exmem_memwrite,
  input  logic            cache_hit,
  input  logic            mem_ready,
  output logic            pcwrite,
  output logic            fdwrite,
  output logic            fdflush,
  output logic            de_write,
  output logic            de_bubble,
  output logic            em_write,
  output logic            mw_bubble,
  output logic            mem_req,
  output logic            miss_err,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MISS_WAIT, MISS_FILL, FLUSH} state_e;

  localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_CYCLES);
  localparam logic [15:0]     TIMEOUT    = 16'(MISS_TIMEOUT);
  localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX    = {CNTW{1'b1}};

  state_e          state_q, state_d;
  logic [15:0]     wait_cnt_q, wait_cnt_d;
  logic [2:0]      flush_left_q, flush_left_d;
  logic            miss_err_q, miss_err_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;

  logic        miss, load_use, flush_evt;
  logic [15:0] wait_inc;
  logic        pc_c, fd_c, fl_c, dew_c, deb_c, em_c, mw_c, mr_c;

  assign miss     = (exmem_memread | exmem_memwrite) & ~cache_hit;
  assign load_use = idex_memread & (idex_rd != 5'd0) &
                    ((ifid_use1 & (ifid_rs1 == idex_rd)) | (ifid_use2 & (ifid_rs2 == idex_rd)));
  assign wait_inc = wait_cnt_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    flush_left_d = flush_left_q;
    miss_err_d   = miss_err_q;
    flush_evt    = 1'b0;
    pc_c  = 1'b0; fd_c  = 1'b0; fl_c = 1'b0; dew_c = 1'b0;
    deb_c = 1'b0; em_c  = 1'b0; mw_c = 1'b0; mr_c  = 1'b0;
    case (state_q)
      RUN, FLUSH: begin
        if (miss) begin
          // A miss in FLUSH drops whatever flush count remains.
          mw_c = 1'b1; mr_c = 1'b1;
          state_d    = MISS_WAIT;
          wait_cnt_d = 16'd0;
        end else if (branch_taken || state_q == FLUSH) begin
          pc_c = 1'b1; fd_c = 1'b1; dew_c = 1'b1; em_c = 1'b1;
          fl_c = 1'b1; deb_c = 1'b1;
          if (branch_taken) begin
            flush_evt = 1'b1;
            if (FLUSH_CYCLES > 0) begin
              state_d      = FLUSH;
              flush_left_d = FLUSH_INIT;
            end
          end else if (flush_left_q <= 3'd1) begin
            state_d      = RUN;
            flush_left_d = 3'd0;
          end else begin
            flush_left_d = flush_left_q - 3'd1;
          end
        end else if (load_use) begin
          dew_c = 1'b1; em_c = 1'b1; deb_c = 1'b1;
        end else begin
          pc_c = 1'b1; fd_c = 1'b1; dew_c = 1'b1; em_c = 1'b1;
        end
      end
      MISS_WAIT: begin
        // branch_taken is ignored here; EX/MEM is frozen so it is presented again later.
        mw_c = 1'b1; mr_c = 1'b1;
        wait_cnt_d = wait_inc;
        if (mem_ready) begin
          state_d = MISS_FILL;
        end else if (wait_inc >= TIMEOUT) begin
          miss_err_d = 1'b1;
          state_d    = MISS_FILL;
        end
      end
      MISS_FILL: begin
        mw_c    = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_c && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (flush_evt && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      wait_cnt_q   <= 16'd0;
      flush_left_q <= 3'd0;
      miss_err_q   <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      flush_left_q <= flush_left_d;
      miss_err_q   <= miss_err_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // Reset forces every enable and control low without waiting for a clock.
  assign pcwrite   = pc_c  & ~rst;
  assign fdwrite   = fd_c  & ~rst;
  assign fdflush   = fl_c  & ~rst;
  assign de_write  = dew_c & ~rst;
  assign de_bubble = deb_c & ~rst;
  assign em_write  = em_c  & ~rst;
  assign mw_bubble = mw_c  & ~rst;
  assign mem_req   = mr_c  & ~rst;
  assign miss_err  = miss_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Generates the write-enable, flush and bubble controls for load-use stalls, taken-branch flushes and data-cache miss stalls.
- Runs an FSM for multi-cycle cache-miss service, with a timeout.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- FLUSH_CYCLES, 1: extra cycles flush/bubble is held after a taken branch (0..7).
- MISS_TIMEOUT, 255: max cycles in MISS_WAIT before error (1..65535).
- CNTW, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- ifid_rs1  in  5  rs1 of the instruction in ID.
- ifid_rs2  in  5  rs2 of the instruction in ID.
- ifid_use1  in  1  ID instruction reads rs1.
- ifid_use2  in  1  ID instruction reads rs2.
- idex_memread  in  1  EX-stage instruction is a load.
- idex_rd  in  5  destination register of the EX-stage instruction.
- branch_taken  in  1  taken branch/jump resolved this cycle (single-cycle pulse).
- exmem_memread  in  1  MEM-stage load.
- exmem_memwrite  in  1  MEM-stage store.
- cache_hit  in  1  data cache hit for the current MEM access.
- mem_ready  in  1  backing memory finished the line fill/writeback.
- pcwrite  out  1  PC register enable.
- fdwrite  out  1  IF/ID enable.
- fdflush  out  1  IF/ID flush (instr forced to 0).
- de_write  out  1  ID/EX enable.
- de_bubble  out  1  zero the ID/EX control fields.
- em_write  out  1  EX/MEM enable.
- mw_bubble  out  1  zero MEM/WB regwrite.
- mem_req  out  1  miss request to backing memory.
- miss_err  out  1  sticky timeout error.
- stall_cnt  out  CNTW  saturating count of stalled cycles.
- flush_cnt  out  CNTW  saturating count of branch flush events.

Behaviour:
- States: RUN, MISS_WAIT, MISS_FILL, FLUSH. State registers, counters and miss_err are reset asynchronously.
- Reset: state=RUN; counters=0; miss_err=0. While rst=1, every enable (pcwrite, fdwrite, de_write, em_write) and every flush/bubble/mem_req output is 0.
- Outputs are combinational from state and current inputs. The pipeline registers sample them on the same clk edge.
- RUN, default: pcwrite=fdwrite=de_write=em_write=1; all other outputs 0.
- Priority in RUN: miss > branch > load-use.
- Miss condition: (exmem_memread|exmem_memwrite) & !cache_hit.
  - All four enables=0; mw_bubble=1; mem_req=1.
  - Next state MISS_WAIT; wait counter cleared.
- MISS_WAIT:
  - Enables=0; mw_bubble=1; mem_req=1; wait counter increments each cycle.
  - mem_ready=1 -> MISS_FILL.
  - Wait counter reaching MISS_TIMEOUT with mem_ready=0: set miss_err (sticky until rst) and go to MISS_FILL.
- MISS_FILL, one cycle: enables=0; mem_req=0; mw_bubble=1. Next state RUN, where the MEM access replays and hits.
- branch_taken in RUN (no miss):
  - fdflush=1 and de_bubble=1; pcwrite=1, fdwrite=1, de_write=1.
  - flush_cnt+1.
  - If FLUSH_CYCLES>0, go to FLUSH with counter=FLUSH_CYCLES.
- FLUSH:
  - Same outputs as a branch cycle; counter decrements; reaching 0 -> RUN.
  - A miss in FLUSH takes priority and goes to MISS_WAIT; the remaining flush count is discarded.
  - A new branch_taken in FLUSH reloads the counter and increments flush_cnt.
- Load-use condition, RUN only, no miss and no branch: idex_memread & idex_rd!=0 & ((ifid_use1 & ifid_rs1==idex_rd) | (ifid_use2 & ifid_rs2==idex_rd)).
  - pcwrite=0, fdwrite=0, de_bubble=1; de_write=1, em_write=1.
  - Stalls exactly one cycle, since the load has then left EX.
- idex_rd=0 never stalls.
- branch_taken with a simultaneous load-use: branch wins, no stall.
- branch_taken asserted while in MISS_WAIT is ignored. The source holds it because EX/MEM is frozen, and it is seen again in RUN.
- stall_cnt increments on every cycle with pcwrite=0 and rst=0, i.e. load-use plus all miss states.
- Both counters saturate at all-ones.

Test Plan:
- Load-use: idex_memread=1, idex_rd=5, ifid_rs1=5, ifid_use1=1 for one cycle -> that cycle pcwrite=0, fdwrite=0, de_bubble=1; next cycle all enables 1; stall_cnt=1.
- Same stimulus with idex_rd=0, or ifid_use1=0 -> no stall; pcwrite=1 throughout.
- Miss: exmem_memread=1, cache_hit=0; mem_ready after 4 cycles -> enables 0 and mem_req=1 for 5 cycles; then MISS_FILL with mem_req=0 and enables 0; then RUN; stall_cnt=6.
- Timeout: MISS_TIMEOUT=8, mem_ready never asserted -> after 8 MISS_WAIT cycles miss_err=1, FSM returns to RUN; miss_err stays 1 until rst.
- Branch: FLUSH_CYCLES=1, branch_taken pulse coincident with load-use -> fdflush=1 and de_bubble=1 for 2 cycles; pcwrite stays 1; flush_cnt=1; stall_cnt unchanged.
- Async reset asserted mid MISS_WAIT, between clock edges -> outputs drop to 0 immediately; after release, state=RUN, counters=0, miss_err=0.
